keypad_scanner: RTL and testbench
=================================

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter SCAN_TICKS, default 50000, CLK cycles per row period (1 ms at 50 MHz); legal range 4..1048575.
REQ-002 SHALL have parameter DEBOUNCE_CNT, default 10, consecutive matching row-period samples needed to accept a press or release; legal range 1..255.
REQ-003 SHALL have port CLK, input, 1, system clock, all logic on rising edge; one clock only.
REQ-004 SHALL have port RESETN, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have port ROW, output, 4, keypad row drive; active-low, exactly one bit low at all times.
REQ-006 SHALL have port COL, input, 4, keypad column sense; active-low, externally pulled up, asynchronous to CLK.
REQ-007 SHALL have port KEY_CODE, output, 4, hex code of last accepted key.
REQ-008 SHALL have port KEY_VALID, output, 1, one-cycle pulse on key acceptance.
REQ-009 SHALL have port KEY_DOWN, output, 1, level; high while an accepted key is held.
REQ-010 SHALL have port DIGITS, output, 16, four hex digits for the display driver, [15:12] oldest, [3:0] newest.

Function
REQ-011 COL SHALL pass through a 2-flop synchronizer before any use.
REQ-012 A row-period counter SHALL count 0..SCAN_TICKS-1 and wrap; the synchronized COL SHALL be sampled only on the cycle the counter equals SCAN_TICKS-1.
REQ-013 A sample is "single" when exactly one COL bit is low, "idle" when all high; two or more low SHALL be treated as idle (ghost reject).
REQ-014 Key map by row r, column c: r0 = 1,2,3,A; r1 = 4,5,6,B; r2 = 7,8,9,C; r3 = 0,F,E,D.
REQ-015 FSM states: SCAN, DEBOUNCE, HELD, RELEASE.
REQ-016 SCAN: ROW advances 0->1->2->3->0 at each wrap; a single sample SHALL capture row/column, freeze ROW, set debounce count to 1, and go to DEBOUNCE (or to HELD directly if DEBOUNCE_CNT=1).
REQ-017 DEBOUNCE: each sample equal to the captured column increments the count; on reaching DEBOUNCE_CNT go to HELD; any other sample SHALL return to SCAN with ROW advancing to the next row.
REQ-018 On entry to HELD, KEY_CODE SHALL update and KEY_VALID SHALL pulse high for exactly one cycle, with KEY_DOWN rising on the same cycle.
REQ-019 HELD: an idle sample SHALL go to RELEASE with release count 1; any other sample, including a different column, stays in HELD; no auto-repeat.
REQ-020 RELEASE: idle samples increment the count; a non-idle sample returns to HELD; on reaching DEBOUNCE_CNT, KEY_DOWN SHALL fall and FSM returns to SCAN at the next row.
REQ-021 Press latency: KEY_VALID fires at the sample DEBOUNCE_CNT-1 row periods after the first single sample, plus one cycle of registration.
REQ-022 KEY_CODE SHALL hold its value until the next acceptance.

Reset
REQ-023 While RESETN is low: ROW=4'b1110, KEY_CODE=0, KEY_VALID=0, KEY_DOWN=0, DIGITS=0, FSM=SCAN, all counters 0, synchronizer flops 4'b1111.
REQ-024 Reset asserted mid-press SHALL abort immediately; after release, a still-held key SHALL be re-debounced and re-reported.

Configuration
REQ-025 Macro DIGIT_SHIFT_EN: when defined, each KEY_VALID SHALL shift DIGITS left by 4 with the new KEY_CODE in [3:0] on the same edge; when undefined, DIGITS SHALL be constant 0 and no shift logic is built.

Verification (SCAN_TICKS=8, DEBOUNCE_CNT=3)
REQ-026 Reset release, no key -> ROW cycles 1110,1101,1011,0111 every 8 cycles; KEY_VALID never pulses.
REQ-027 Hold row2/col1 stably -> ROW freezes at 1011, one KEY_VALID pulse, KEY_CODE=8, KEY_DOWN=1 until 3 idle samples after release.
REQ-028 Row0/col3 bouncing (single, idle, single, single, single) -> exactly one KEY_VALID, KEY_CODE=A, first at the fifth sample.
REQ-029 Row1 with col0 and col2 low together -> no KEY_VALID, scanning continues.
REQ-030 With DIGIT_SHIFT_EN, press 1,2,3,4,5 -> DIGITS=16'h2345; without, DIGITS=0.
REQ-031 RESETN pulsed low while in HELD -> outputs at reset values within the same cycle; key still held -> re-reported after debounce.

Source files
------------

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 active-low matrix keypad scanner with ghost rejection and press/release debounce.
// Optional macro DIGIT_SHIFT_EN builds a four-digit shift register of accepted keys on DIGITS.
module keypad_scanner #(
  parameter int SCAN_TICKS   = 50000,
  parameter int DEBOUNCE_CNT = 10
) (
  input  logic        CLK,
  input  logic        RESETN,
  output logic [3:0]  ROW,
  input  logic [3:0]  COL,
  output logic [3:0]  KEY_CODE,
  output logic        KEY_VALID,
  output logic        KEY_DOWN,
  output logic [15:0] DIGITS
);

  // state    | meaning
  // SCAN     | stepping rows each period, looking for a single-key sample
  // DEBOUNCE | row frozen, counting samples that match the captured column
  // HELD     | key accepted and reported, waiting for an idle sample
  // RELEASE  | counting idle samples before declaring the key released
  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

  localparam int            TW        = $clog2(SCAN_TICKS);
  localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_TICKS - 1);
  localparam logic [7:0]    DB_LAST   = 8'(DEBOUNCE_CNT);

  state_t        state, state_nxt;
  logic [3:0]    col_s1, col_s2;
  logic [TW-1:0] tick;
  logic [1:0]    row_idx, row_nxt;
  logic [1:0]    col_idx, col_nxt;
  logic [7:0]    cnt, cnt_nxt, cnt_inc;
  logic          sample, single, accept, release_done;
  logic [1:0]    hit_col;
  logic [3:0]    code_nxt;

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    case ({r, c})
      4'h0:    k = 4'h1;
      4'h1:    k = 4'h2;
      4'h2:    k = 4'h3;
      4'h3:    k = 4'hA;
      4'h4:    k = 4'h4;
      4'h5:    k = 4'h5;
      4'h6:    k = 4'h6;
      4'h7:    k = 4'hB;
      4'h8:    k = 4'h7;
      4'h9:    k = 4'h8;
      4'hA:    k = 4'h9;
      4'hB:    k = 4'hC;
      4'hD:    k = 4'hF;
      4'hE:    k = 4'hE;
      4'hF:    k = 4'hD;
      default: k = 4'h0;
    endcase
    return k;
  endfunction

  assign sample   = (tick == TICK_LAST);
  assign cnt_inc  = cnt + 8'd1;
  assign code_nxt = key_map(row_idx, hit_col);

  // Two or more low columns decode as idle so ghosted combinations are ignored.
  always_comb begin
    single  = 1'b1;
    hit_col = 2'd0;
    case (col_s2)
      4'b1110: hit_col = 2'd0;
      4'b1101: hit_col = 2'd1;
      4'b1011: hit_col = 2'd2;
      4'b0111: hit_col = 2'd3;
      default: single  = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) state <= SCAN;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    row_nxt      = row_idx;
    col_nxt      = col_idx;
    cnt_nxt      = cnt;
    accept       = 1'b0;
    release_done = 1'b0;
    if (sample) begin
      case (state)
        SCAN: begin
          if (single) begin
            col_nxt = hit_col;
            if (DB_LAST == 8'd1) begin
              state_nxt = HELD;
              accept    = 1'b1;
              cnt_nxt   = 8'd0;
            end else begin
              state_nxt = DEBOUNCE;
              cnt_nxt   = 8'd1;
            end
          end else begin
            row_nxt = row_idx + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (single && hit_col == col_idx) begin
            if (cnt_inc == DB_LAST) begin
              state_nxt = HELD;
              accept    = 1'b1;
              cnt_nxt   = 8'd0;
            end else begin
              cnt_nxt = cnt_inc;
            end
          end else begin
            state_nxt = SCAN;
            row_nxt   = row_idx + 2'd1;
            cnt_nxt   = 8'd0;
          end
        end
        HELD: begin
          if (!single) begin
            if (DB_LAST == 8'd1) begin
              state_nxt    = SCAN;
              release_done = 1'b1;
              row_nxt      = row_idx + 2'd1;
              cnt_nxt      = 8'd0;
            end else begin
              state_nxt = RELEASE;
              cnt_nxt   = 8'd1;
            end
          end
        end
        RELEASE: begin
          if (single) begin
            state_nxt = HELD;
            cnt_nxt   = 8'd0;
          end else if (cnt_inc == DB_LAST) begin
            state_nxt    = SCAN;
            release_done = 1'b1;
            row_nxt      = row_idx + 2'd1;
            cnt_nxt      = 8'd0;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
        default: state_nxt = SCAN;
      endcase
    end
  end

  // ROW is registered so the row drive never glitches through a decode.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      col_s1    <= 4'b1111;
      col_s2    <= 4'b1111;
      tick      <= '0;
      row_idx   <= 2'd0;
      col_idx   <= 2'd0;
      cnt       <= 8'd0;
      ROW       <= 4'b1110;
      KEY_CODE  <= 4'h0;
      KEY_VALID <= 1'b0;
      KEY_DOWN  <= 1'b0;
    end else begin
      col_s1    <= COL;
      col_s2    <= col_s1;
      tick      <= sample ? '0 : tick + TW'(1);
      row_idx   <= row_nxt;
      col_idx   <= col_nxt;
      cnt       <= cnt_nxt;
      ROW       <= ~(4'b0001 << row_nxt);
      KEY_VALID <= accept;
      if (accept) KEY_CODE <= code_nxt;
      if (accept)            KEY_DOWN <= 1'b1;
      else if (release_done) KEY_DOWN <= 1'b0;
    end
  end

`ifdef DIGIT_SHIFT_EN
  logic [15:0] digits;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN)     digits <= 16'h0000;
    else if (accept) digits <= {digits[11:0], code_nxt};
  end

  assign DIGITS = digits;
`else
  assign DIGITS = 16'h0000;
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: directed scenarios plus randomized presses against a per-sample keypad model.
module tb_keypad_scanner;
  localparam int ST = 8;
  localparam int DB = 3;

  logic        CLK = 1'b0;
  logic        RESETN = 1'b0;
  logic [3:0]  ROW, COL, KEY_CODE;
  logic        KEY_VALID, KEY_DOWN;
  logic [15:0] DIGITS;

  logic       key_en = 1'b0, ghost_en = 1'b0, bounce = 1'b0;
  logic [1:0] key_r = 2'd0, key_c = 2'd0, ghost_c = 2'd0;

  int n_cmp = 0, n_bad = 0, n_pulse = 0;

  int          m_row, m_col, m_run, m_idle;
  bit          m_lock, m_down, m_valid;
  logic [3:0]  m_code;
  logic [15:0] m_digits;
  logic [3:0]  key_tab [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                                4'h7, 4'h8, 4'h9, 4'hC, 4'h0, 4'hF, 4'hE, 4'hD};

  always #5 CLK = ~CLK;

  keypad_scanner #(.SCAN_TICKS(ST), .DEBOUNCE_CNT(DB)) dut (
    .CLK(CLK), .RESETN(RESETN), .ROW(ROW), .COL(COL),
    .KEY_CODE(KEY_CODE), .KEY_VALID(KEY_VALID), .KEY_DOWN(KEY_DOWN), .DIGITS(DIGITS)
  );

  // Physical keypad: the held key pulls its column low while its row is driven.
  always_comb begin
    COL = 4'hF;
    if (key_en && !bounce && !ROW[key_r]) begin
      COL[key_c] = 1'b0;
      if (ghost_en) COL[ghost_c] = 1'b0;
    end
  end

  always @(posedge CLK) if (KEY_VALID === 1'b1) n_pulse++;

  initial begin
    #900000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_row = 0; m_col = 0; m_run = 0; m_idle = 0;
    m_lock = 0; m_down = 0; m_valid = 0;
    m_code = 4'h0; m_digits = 16'h0000;
  endtask

  function automatic logic [3:0] pad_model(input int r);
    logic [3:0] c;
    c = 4'hF;
    if (key_en && !bounce && int'(key_r) == r) begin
      c[key_c] = 1'b0;
      if (ghost_en) c[ghost_c] = 1'b0;
    end
    return c;
  endfunction

  // One row-period sample seen from the keypad's point of view.
  task automatic model_step();
    logic [3:0] s;
    int lows, c;
    s = pad_model(m_row);
    lows = $countones(~s);
    c = 0;
    for (int i = 0; i < 4; i++) if (!s[i]) c = i;
    m_valid = 0;
    if (m_down) begin
      if (lows != 1) begin
        m_idle++;
        if (m_idle == DB) begin
          m_down = 0; m_lock = 0; m_row = (m_row + 1) % 4;
        end
      end else begin
        m_idle = 0;
      end
    end else if (lows == 1 && (!m_lock || c == m_col)) begin
      if (!m_lock) begin m_lock = 1; m_col = c; m_run = 0; end
      m_run++;
      if (m_run == DB) begin
        m_down = 1; m_valid = 1; m_idle = 0;
        m_code = key_tab[m_row * 4 + m_col];
`ifdef DIGIT_SHIFT_EN
        m_digits = {m_digits[11:0], m_code};
`endif
      end
    end else begin
      m_lock = 0; m_row = (m_row + 1) % 4;
    end
  endtask

  task automatic period();
    logic [3:0] er;
    for (int k = 1; k < ST; k++) begin
      @(posedge CLK); #1;
      chk("valid_quiet", KEY_VALID, 0);
    end
    model_step();
    @(posedge CLK); #1;
    er = ~(4'b0001 << m_row);
    chk("row", ROW, er);
    chk("valid", KEY_VALID, m_valid);
    chk("down", KEY_DOWN, m_down);
    chk("code", KEY_CODE, m_code);
    chk("digits", DIGITS, m_digits);
  endtask

  task automatic run_until(input bit want, input string tag);
    int n;
    n = 0;
    while (m_down != want && n < 60) begin period(); n++; end
    if (m_down != want) begin
      n_cmp++; n_bad++;
      $error("FAIL %s observed=timeout expected=key_down_%0d", tag, want);
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESETN = 1'b0;
    #2;
    chk("rst_row", ROW, 4'b1110);
    chk("rst_valid", KEY_VALID, 0);
    chk("rst_down", KEY_DOWN, 0);
    chk("rst_code", KEY_CODE, 0);
    chk("rst_digits", DIGITS, 0);
    @(negedge CLK);
    RESETN = 1'b1;
    model_reset();
  endtask

  task automatic press(input logic [1:0] r, input logic [1:0] c, input string tag);
    key_r = r; key_c = c; key_en = 1'b1;
    run_until(1'b1, tag);
    period();
    key_en = 1'b0;
    run_until(1'b0, tag);
  endtask

  initial begin
    int p0, hold;
    logic [15:0] exp_dig;
    model_reset();
    do_reset();

    // Idle scanning: ROW walks the rows, no key reported.
    for (int i = 0; i < 8; i++) period();
    chk("idle_pulses", n_pulse, 0);

    // Stable row2/col1 hold.
    key_r = 2'd2; key_c = 2'd1; key_en = 1'b1;
    run_until(1'b1, "hold_8");
    chk("hold_code", KEY_CODE, 4'h8);
    for (int i = 0; i < 4; i++) period();
    chk("hold_row", ROW, 4'b1011);
    chk("hold_pulses", n_pulse, 1);
    key_en = 1'b0;
    run_until(1'b0, "release_8");

    // Bouncing row0/col3.
    do_reset();
    p0 = n_pulse;
    key_r = 2'd0; key_c = 2'd3; key_en = 1'b1;
    period();
    bounce = 1'b1; period(); bounce = 1'b0;
    run_until(1'b1, "bounce_A");
    period();
    chk("bounce_pulses", n_pulse - p0, 1);
    chk("bounce_code", KEY_CODE, 4'hA);
    key_en = 1'b0;
    run_until(1'b0, "release_A");

    // Ghost: two columns low on row1.
    p0 = n_pulse;
    key_r = 2'd1; key_c = 2'd0; ghost_c = 2'd2; ghost_en = 1'b1; key_en = 1'b1;
    for (int i = 0; i < 12; i++) period();
    chk("ghost_pulses", n_pulse - p0, 0);
    key_en = 1'b0; ghost_en = 1'b0;

    // Keys 1..5 into the digit register.
    press(2'd0, 2'd0, "key1");
    press(2'd0, 2'd1, "key2");
    press(2'd0, 2'd2, "key3");
    press(2'd1, 2'd0, "key4");
    press(2'd1, 2'd1, "key5");
`ifdef DIGIT_SHIFT_EN
    exp_dig = 16'h2345;
`else
    exp_dig = 16'h0000;
`endif
    chk("digits_12345", DIGITS, exp_dig);

    // Reset while HELD, key still down: aborted then re-reported.
    key_r = 2'd2; key_c = 2'd2; key_en = 1'b1;
    run_until(1'b1, "pre_reset_9");
    period();
    do_reset();
    run_until(1'b1, "rereport_9");
    chk("rereport_code", KEY_CODE, 4'h9);
    key_en = 1'b0;
    run_until(1'b0, "release_9");

    // Randomized presses with chatter and occasional ghosting.
    for (int t = 0; t < 10; t++) begin
      key_r = 2'($urandom_range(0, 3));
      key_c = 2'($urandom_range(0, 3));
      ghost_c = key_c ^ 2'd1;
      hold = $urandom_range(4, 20);
      for (int p = 0; p < hold; p++) begin
        key_en = ($urandom_range(0, 5) != 0);
        ghost_en = ($urandom_range(0, 9) == 0);
        period();
      end
      key_en = 1'b0; ghost_en = 1'b0;
      run_until(1'b0, "rand_release");
      period();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
